// File: rtl/gpio_apb_arbiter.sv
// Two-requester round-robin APB arbiter in front of the GPIO slave.
// Runs one downstream transfer at a time and returns PSLVERR if the slave stalls.
module gpio_apb_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic [1:0]            s_psel,
   input  logic [1:0]            s_penable,
   input  logic [1:0]            s_pwrite,
   input  logic [2*ADDR_W-1:0]   s_paddr,
   input  logic [2*DATA_W-1:0]   s_pwdata,
   output logic [DATA_W-1:0]     s_prdata,
   output logic [1:0]            s_pready,
   output logic [1:0]            s_pslverr,
   output logic                  m_psel,
   output logic                  m_penable,
   output logic                  m_pwrite,
   output logic [ADDR_W-1:0]     m_paddr,
   output logic [DATA_W-1:0]     m_pwdata,
   input  logic [DATA_W-1:0]     m_prdata,
   input  logic                  m_pready,
   input  logic                  m_pslverr,
   output logic [1:0]            grant
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t              state, state_nxt;
   logic                rr_ptr;
   logic [TW-1:0]       timer;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                win1;
   logic                timeout_hit;
   logic                in_resp;

   // PENABLE from the requesters carries no extra information here: a request is PSEL alone.
   logic unused_penable;
   assign unused_penable = &{1'b0, s_penable};

   assign win1        = s_psel[1] & (~s_psel[0] | rr_ptr);
   assign timeout_hit = (TIMEOUT != 0) && (timer == TO_LAST);
   assign in_resp     = (state == RESP);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|s_psel) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (m_pready || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state    <= IDLE;
         rr_ptr   <= 1'b0;
         timer    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         grant    <= '0;
         m_pwrite <= 1'b0;
         m_paddr  <= '0;
         m_pwdata <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (|s_psel) begin
                  grant    <= win1 ? 2'b10 : 2'b01;
                  m_pwrite <= win1 ? s_pwrite[1] : s_pwrite[0];
                  m_paddr  <= win1 ? s_paddr[2*ADDR_W-1:ADDR_W] : s_paddr[ADDR_W-1:0];
                  m_pwdata <= win1 ? s_pwdata[2*DATA_W-1:DATA_W] : s_pwdata[DATA_W-1:0];
               end
            end
            SETUP: timer <= '0;
            ACCESS: begin
               if (m_pready) begin
                  rdata_q <= m_prdata;
                  err_q   <= m_pslverr;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end
            RESP: begin
               grant  <= '0;
               rr_ptr <= ~grant[1];
            end
            default: ;
         endcase
      end
   end

   // Strobes are decoded from registered state/grant only, so they drop with the async reset.
   assign m_psel    = (state == SETUP) || (state == ACCESS);
   assign m_penable = (state == ACCESS);
   assign s_pready  = in_resp ? grant : 2'b00;
   assign s_pslverr = (in_resp && err_q) ? grant : 2'b00;
   assign s_prdata  = in_resp ? rdata_q : '0;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed bench for gpio_apb_arbiter with a small behavioural GPIO slave.
module tb_gpio_apb_arbiter;

   logic          PCLK;
   logic          PRESET;
   logic [1:0]    s_psel, s_penable, s_pwrite;
   logic [7:0]    a0, a1;
   logic [31:0]   w0, w1;
   logic [15:0]   s_paddr;
   logic [63:0]   s_pwdata;
   logic [31:0]   s_prdata;
   logic [1:0]    s_pready, s_pslverr;
   logic          m_psel, m_penable, m_pwrite;
   logic [7:0]    m_paddr;
   logic [31:0]   m_pwdata, m_prdata;
   logic          m_pready, m_pslverr;
   logic [1:0]    grant;

   int            checks = 0;
   int            errors = 0;
   int            slave_waits = 0;
   logic          slave_hang = 1'b0;
   int            wait_cnt = 0;

   assign s_paddr  = {a1, a0};
   assign s_pwdata = {w1, w0};
   assign s_penable = s_psel;

   // Slave: read data derived from address, error on 0x20, programmable wait states.
   assign m_pready  = m_psel && m_penable && !slave_hang && (wait_cnt >= slave_waits);
   assign m_prdata  = 32'hC0DE_0000 | {24'b0, m_paddr};
   assign m_pslverr = m_pready && (m_paddr == 8'h20);

   always @(posedge PCLK) begin
      if (m_psel && m_penable && !m_pready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   gpio_apb_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata),
      .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
      .grant(grant)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int n, input int budget, output int steps);
      steps = 0;
      do begin
         step();
         steps++;
      end while (!s_pready[n] && steps < budget);
      chk("wait_ready", {31'b0, s_pready[n]}, 32'd1);
   endtask

   initial begin
      int n;
      int pen;
      PRESET = 1'b1;
      s_psel = '0; s_pwrite = '0;
      a0 = '0; a1 = '0; w0 = '0; w1 = '0;
      #12;
      chk("rst_m_psel",    {31'b0, m_psel},    32'd0);
      chk("rst_m_penable", {31'b0, m_penable}, 32'd0);
      chk("rst_grant",     {30'b0, grant},     32'd0);
      chk("rst_s_pready",  {30'b0, s_pready},  32'd0);
      chk("rst_s_prdata",  s_prdata,           32'd0);
      chk("rst_m_paddr",   {24'b0, m_paddr},   32'd0);
      #3 PRESET = 1'b0;
      step();

      // T1: req0 write, zero-wait slave
      s_psel = 2'b01; a0 = 8'h04; s_pwrite = 2'b01; w0 = 32'hA5A5_00FF;
      chk("t1_idle_psel", {31'b0, m_psel}, 32'd0);
      step();
      chk("t1_setup_psel",    {31'b0, m_psel},    32'd1);
      chk("t1_setup_penable", {31'b0, m_penable}, 32'd0);
      chk("t1_setup_grant",   {30'b0, grant},     32'd1);
      chk("t1_setup_paddr",   {24'b0, m_paddr},   32'h04);
      chk("t1_setup_pwdata",  m_pwdata,           32'hA5A5_00FF);
      chk("t1_setup_pwrite",  {31'b0, m_pwrite},  32'd1);
      step();
      chk("t1_access_penable", {31'b0, m_penable}, 32'd1);
      chk("t1_access_pready",  {30'b0, s_pready},  32'd0);
      step();
      chk("t1_resp_pready",  {30'b0, s_pready},  32'd1);
      chk("t1_resp_pslverr", {30'b0, s_pslverr}, 32'd0);
      chk("t1_resp_prdata",  s_prdata,           32'hC0DE_0004);
      chk("t1_resp_psel",    {31'b0, m_psel},    32'd0);
      s_psel = 2'b00; s_pwrite = 2'b00;
      step();
      chk("t1_after_pready", {30'b0, s_pready}, 32'd0);
      chk("t1_after_grant",  {30'b0, grant},    32'd0);
      chk("t1_after_prdata", s_prdata,          32'd0);

      // T3: req1 alone, three back-to-back reads (RESP->IDLE->SETUP->ACCESS->RESP = 4 cycles)
      s_psel = 2'b10;
      for (int i = 0; i < 3; i++) begin
         a1 = 8'(8'h10 + 4 * i);
         wait_ready(1, 10, n);
         chk("t3_latency", n, (i == 0) ? 32'd3 : 32'd4);
         chk("t3_pready",  {30'b0, s_pready}, 32'd2);
         chk("t3_grant",   {30'b0, grant},    32'd2);
         chk("t3_prdata",  s_prdata, 32'hC0DE_0010 + 32'(4 * i));
      end
      s_psel = 2'b00;
      step();

      // T2: simultaneous reads of 0x08, rr_ptr back at req0
      s_psel = 2'b11; a0 = 8'h08; a1 = 8'h08;
      wait_ready(0, 10, n);
      chk("t2_r0_latency", n, 32'd3);
      chk("t2_r0_pready",  {30'b0, s_pready}, 32'd1);
      chk("t2_r0_grant",   {30'b0, grant},    32'd1);
      chk("t2_r0_prdata",  s_prdata, 32'hC0DE_0008);
      s_psel = 2'b10;
      wait_ready(1, 10, n);
      chk("t2_r1_latency", n, 32'd4);
      chk("t2_r1_pready",  {30'b0, s_pready}, 32'd2);
      chk("t2_r1_grant",   {30'b0, grant},    32'd2);
      s_psel = 2'b00;
      step();

      // T5: three wait states and slave error on 0x20
      slave_waits = 3;
      s_psel = 2'b01; a0 = 8'h20;
      wait_ready(0, 20, n);
      chk("t5_latency", n, 32'd6);
      chk("t5_pslverr", {30'b0, s_pslverr}, 32'd1);
      chk("t5_prdata",  s_prdata, 32'hC0DE_0020);
      s_psel = 2'b00; slave_waits = 0;
      step();

      // T4: stalled slave, watchdog after 16 ACCESS cycles
      slave_hang = 1'b1;
      s_psel = 2'b10; a1 = 8'h0C;
      n = 0; pen = 0;
      while (n < 40 && !s_pready[1]) begin
         step();
         n++;
         if (m_penable) pen++;
      end
      chk("t4_pready",   {30'b0, s_pready},  32'd2);
      chk("t4_pslverr",  {30'b0, s_pslverr}, 32'd2);
      chk("t4_prdata",   s_prdata, 32'd0);
      chk("t4_access_n", pen, 32'd16);
      chk("t4_latency",  n, 32'd18);
      s_psel = 2'b00; slave_hang = 1'b0;
      step();
      chk("t4_after_pready", {30'b0, s_pready}, 32'd0);

      // T6: async reset during ACCESS, then normal service
      slave_hang = 1'b1;
      s_psel = 2'b01; a0 = 8'h14; s_pwrite = 2'b01; w0 = 32'h1234_5678;
      step();
      step();
      chk("t6_access_penable", {31'b0, m_penable}, 32'd1);
      #2 PRESET = 1'b1;
      #1;
      chk("t6_rst_psel",    {31'b0, m_psel},    32'd0);
      chk("t6_rst_penable", {31'b0, m_penable}, 32'd0);
      chk("t6_rst_grant",   {30'b0, grant},     32'd0);
      chk("t6_rst_pready",  {30'b0, s_pready},  32'd0);
      #2 PRESET = 1'b0; slave_hang = 1'b0;
      wait_ready(0, 10, n);
      chk("t6_latency", n, 32'd3);
      chk("t6_pready",  {30'b0, s_pready}, 32'd1);
      chk("t6_grant",   {30'b0, grant},    32'd1);
      chk("t6_prdata",  s_prdata, 32'hC0DE_0014);
      s_psel = 2'b00; s_pwrite = 2'b00;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
